mem_port_initiator: RTL

//   Requester side of one port of the dual-port async-read / sync-write byte-enable RAM.

---
 rtl/mem_port_initiator.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_initiator.sv
// mem_port_initiator
//   Requester side of one port of a dual-port RAM with async read, sync write
//   and byte enables. It turns a CPU load/store (byte address, size, sign) into
//   one or two RAM word accesses:
//     - It generates byte enables and lane-shifts store data.
//     - It aligns load data and sign- or zero-extends it.
//     - An access that crosses a word boundary is split into two consecutive
//       RAM accesses (ACC1 to word w, then ACC2 to word w+1, mod 2^AWIDTH).
//
//   Handshake: a request is taken in any cycle where req_valid && req_ready.
//   req_ready is high only in IDLE. rsp_valid is a one-cycle pulse, with no
//   backpressure, in the cycle after the last RAM access. rsp_rdata is valid
//   with that pulse and is 0 for stores.
//
//   Ports
//     clk, rst_n                  clock; synchronous active-low reset
//     req_valid / req_ready       request handshake
//     req_we, req_size,           store flag, size (0 byte, 1 half, else word),
//     req_unsigned                zero-extend select
//     req_addr, req_wdata         byte address (little-endian), right-justified data
//     rsp_valid, rsp_rdata        completion pulse and load result
//     mem_addr, mem_d             RAM word address and lane-aligned write data
//     mem_wen, mem_wbe            RAM write enable and byte enables (gated by rst_n)
//     mem_q                       RAM async read data for mem_addr
//
//   The FSM state is held in the signal `state` (IDLE/ACC1/ACC2) so that a
//   checker can be bound to it.
module mem_port_initiator #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    output logic              mem_wen,
    output logic [3:0]        mem_wbe,
    input  logic [DWIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Request captured at accept
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [1:0]        r_o;
    logic [AWIDTH-1:0] r_w;
    logic [DWIDTH-1:0] r_wdata;

    // Low word of a split load, captured at the end of ACC1
    logic [DWIDTH-1:0] lo;

    // mem_addr / mem_d hold their last driven values outside the access states
    logic [AWIDTH-1:0] addr_hold;
    logic [DWIDTH-1:0] d_hold;

    logic [2:0] n_bytes;
    logic [7:0] mask;
    logic       split;

    always_comb begin
        case (r_size)
            2'd0:    n_bytes = 3'd1;
            2'd1:    n_bytes = 3'd2;
            default: n_bytes = 3'd4;
        endcase
    end

    // The 8-bit mask spans two words: [3:0] for word w and [7:4] for word w+1.
    always_comb begin
        case (r_size)
            2'd0:    mask = 8'h01 << r_o;
            2'd1:    mask = 8'h03 << r_o;
            default: mask = 8'h0F << r_o;
        endcase
    end

    assign split = (({1'b0, r_o} + n_bytes) > 3'd4);

    // Shift {hi, lo} right by the byte offset, keep one word, then extend.
    function automatic logic [DWIDTH-1:0] align_load(
        input logic [DWIDTH-1:0] hi,
        input logic [DWIDTH-1:0] lo_in,
        input logic [1:0]        o,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DWIDTH-1:0] raw;
        raw = DWIDTH'({hi, lo_in} >> {o, 3'b000});
        case (size)
            2'd0:    align_load = uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    align_load = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: align_load = raw;
        endcase
    endfunction

    assign req_ready = (state == IDLE);

    // Next state and RAM-side outputs
    always_comb begin
        state_nxt = state;
        mem_addr  = addr_hold;
        mem_d     = d_hold;
        mem_wbe   = 4'b0000;
        mem_wen   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = ACC1;
                end
            end
            ACC1: begin
                state_nxt = split ? ACC2 : IDLE;
                mem_addr  = r_w;
                mem_d     = r_wdata << {r_o, 3'b000};
                mem_wbe   = (rst_n && r_we) ? mask[3:0] : 4'b0000;
                mem_wen   = rst_n && r_we;
            end
            ACC2: begin
                state_nxt = IDLE;
                mem_addr  = r_w + {{(AWIDTH-1){1'b0}}, 1'b1};
                // Only reached when the offset is non-zero, so the shift is 8..24.
                mem_d     = r_wdata >> (6'd32 - {1'b0, r_o, 3'b000});
                mem_wbe   = (rst_n && r_we) ? mask[7:4] : 4'b0000;
                mem_wen   = rst_n && r_we;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_o       <= 2'd0;
            r_w       <= '0;
            r_wdata   <= '0;
            lo        <= '0;
            addr_hold <= '0;
            d_hold    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;

            if (state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_o     <= req_addr[1:0];
                r_w     <= req_addr[AWIDTH+1:2];
                r_wdata <= req_wdata;
            end

            if (state == ACC1 || state == ACC2) begin
                addr_hold <= mem_addr;
                d_hold    <= mem_d;
            end

            if (state == ACC1) begin
                lo <= mem_q;
                if (!split) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= r_we ? '0 : align_load('0, mem_q, r_o, r_size, r_uns);
                end
            end

            if (state == ACC2) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= r_we ? '0 : align_load(mem_q, lo, r_o, r_size, r_uns);
            end
        end
    end

endmodule
